// File: rtl/pc_write_controller_pkg.sv
// Shared fetch-stage definitions for the PC write controller and its next-PC mux.
package pc_write_controller_pkg;

    localparam int DEFAULT_NB = 32;
    localparam int PC_INCR    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    function automatic logic is_running(input state_t st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/pc_write_controller_next_pc_mux.sv
// Priority selection of the next PC (jump > branch > pending redirect > PC+4) and IF/ID flush flag.
module pc_write_controller_next_pc_mux
    import pc_write_controller_pkg::*;
#(
    parameter int NB = DEFAULT_NB
) (
    input  logic          adv,
    input  logic [NB-1:0] pc,
    input  logic          jump,
    input  logic [NB-1:0] jump_target,
    input  logic          branch_taken,
    input  logic [NB-1:0] branch_target,
    input  logic          pend_valid,
    input  logic [NB-1:0] pend_target,
    output logic [NB-1:0] new_pc,
    output logic          redirect,
    output logic          flush
);

    logic [NB-1:0] pc_plus;

    assign pc_plus  = pc + NB'(PC_INCR);
    assign redirect = jump | branch_taken | pend_valid;
    assign flush    = adv & redirect;

    // Off the advance path the value is a don't-care, so sequential PC is presented.
    always_comb begin
        new_pc = pc_plus;
        if (adv) begin
            if (jump) begin
                new_pc = jump_target;
            end else if (branch_taken) begin
                new_pc = branch_target;
            end else if (pend_valid) begin
                new_pc = pend_target;
            end
        end
    end

endmodule

// File: rtl/pc_write_controller.sv
// Fetch-stage PC write controller: run/step/halt FSM, pending redirect register and advance counter.
module pc_write_controller
    import pc_write_controller_pkg::*;
#(
    parameter int NB    = DEFAULT_NB,
    parameter int CNT_W = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [NB-1:0]    i_pc,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [NB-1:0]    i_branch_target,
    input  logic             i_jump,
    input  logic [NB-1:0]    i_jump_target,
    input  logic             i_halt_detected,
    output logic             o_write_new_pc,
    output logic [NB-1:0]    o_new_pc,
    output logic             o_flush_if_id,
    output logic             o_halted,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_count
);

    state_t           state;
    state_t           state_next;
    logic             pend_valid;
    logic [NB-1:0]    pend_target;
    logic [CNT_W-1:0] cycle_count;

    logic             adv;
    logic             redirect;
    logic             mux_flush;
    logic [NB-1:0]    mux_new_pc;
    logic             halt_take;
    logic             write_pc;

    assign adv       = is_running(state) & ~i_stall;
    assign halt_take = adv & i_halt_detected & ~redirect;
    assign write_pc  = adv & ~halt_take;

    pc_write_controller_next_pc_mux #(
        .NB(NB)
    ) u_next_pc_mux (
        .adv           (adv),
        .pc            (i_pc),
        .jump          (i_jump),
        .jump_target   (i_jump_target),
        .branch_taken  (i_branch_taken),
        .branch_target (i_branch_target),
        .pend_valid    (pend_valid),
        .pend_target   (pend_target),
        .new_pc        (mux_new_pc),
        .redirect      (redirect),
        .flush         (mux_flush)
    );

    always_comb begin
        o_write_new_pc = 1'b0;
        o_new_pc       = '0;
        o_flush_if_id  = 1'b0;
        if (!i_reset) begin
            o_write_new_pc = write_pc;
            o_new_pc       = mux_new_pc;
            o_flush_if_id  = mux_flush;
        end
    end

    assign o_halted      = (state == ST_HALTED);
    assign o_state       = state;
    assign o_cycle_count = cycle_count;

    // A HALT that is actually taken overrides the normal RUN/STEP exits.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_run) begin
                    state_next = ST_RUN;
                end else if (i_step) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_take) begin
                    state_next = ST_HALTED;
                end else if (!i_run) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (halt_take) begin
                    state_next = ST_HALTED;
                end else if (adv) begin
                    state_next = ST_IDLE;
                end
            end
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Any advancing cycle consumes the pending redirect, either by applying it or by a newer live one.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (adv) begin
            pend_valid  <= 1'b0;
        end else if (i_jump || i_branch_taken) begin
            pend_valid  <= 1'b1;
            pend_target <= i_jump ? i_jump_target : i_branch_target;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cycle_count <= '0;
        end else if (write_pc && (cycle_count != {CNT_W{1'b1}})) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_write_controller.sv
// Directed plus randomized bench for pc_write_controller against a cycle-level behavioural model.
module tb_pc_write_controller;

    localparam int NB    = 32;
    localparam int CNT_W = 4;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic             i_clock;
    logic             i_reset;
    logic [NB-1:0]    i_pc;
    logic             i_run;
    logic             i_step;
    logic             i_stall;
    logic             i_branch_taken;
    logic [NB-1:0]    i_branch_target;
    logic             i_jump;
    logic [NB-1:0]    i_jump_target;
    logic             i_halt_detected;
    logic             o_write_new_pc;
    logic [NB-1:0]    o_new_pc;
    logic             o_flush_if_id;
    logic             o_halted;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_cycle_count;

    int total = 0;
    int bad   = 0;

    // Model: mode 0=idle 1=run 2=step 3=halted; pc is the program counter the bench plays.
    int          m_mode;
    bit          m_pend_v;
    logic [31:0] m_pend_t;
    longint      m_count;
    logic [31:0] pc;

    pc_write_controller #(
        .NB(NB),
        .CNT_W(CNT_W)
    ) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_pc            (i_pc),
        .i_run           (i_run),
        .i_step          (i_step),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .i_halt_detected (i_halt_detected),
        .o_write_new_pc  (o_write_new_pc),
        .o_new_pc        (o_new_pc),
        .o_flush_if_id   (o_flush_if_id),
        .o_halted        (o_halted),
        .o_state         (o_state),
        .o_cycle_count   (o_cycle_count)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit run, input bit step, input bit stall,
                                 input bit br, input logic [31:0] bt,
                                 input bit jmp, input logic [31:0] jt, input bit halt);
        @(negedge i_clock);
        i_reset         = rst;
        i_run           = run;
        i_step          = step;
        i_stall         = stall;
        i_branch_taken  = br;
        i_branch_target = bt;
        i_jump          = jmp;
        i_jump_target   = jt;
        i_halt_detected = halt;
        i_pc            = pc;
    endtask

    // Checks the combinational decision for the current cycle, then advances the model past the edge.
    task automatic checkOutput();
        bit          running;
        bit          redir;
        bit          halt_act;
        bit          e_we;
        bit          e_fl;
        logic [31:0] e_pc;
        logic [31:0] seq_pc;
        #1;
        running  = (m_mode == 1 || m_mode == 2) && !i_stall;
        redir    = i_jump || i_branch_taken || m_pend_v;
        halt_act = running && i_halt_detected && !redir;
        seq_pc   = pc + 32'd4;
        if (!running)          e_pc = seq_pc;
        else if (i_jump)         e_pc = i_jump_target;
        else if (i_branch_taken) e_pc = i_branch_target;
        else if (m_pend_v)       e_pc = m_pend_t;
        else                     e_pc = seq_pc;
        e_we = running && !halt_act;
        e_fl = running && redir;
        if (i_reset) begin
            e_we = 1'b0;
            e_pc = 32'd0;
            e_fl = 1'b0;
        end
        checkVal("write_new_pc", {63'd0, o_write_new_pc}, {63'd0, e_we});
        checkVal("new_pc", {32'd0, o_new_pc}, {32'd0, e_pc});
        checkVal("flush_if_id", {63'd0, o_flush_if_id}, {63'd0, e_fl});
        checkVal("state", {62'd0, o_state}, 64'(m_mode));
        checkVal("halted", {63'd0, o_halted}, {63'd0, (m_mode == 3)});
        checkVal("cycle_count", {60'd0, o_cycle_count}, 64'(m_count));
        @(posedge i_clock);
        if (i_reset) begin
            m_mode   = 0;
            m_pend_v = 1'b0;
            m_count  = 0;
            pc       = 32'd0;
        end else begin
            if (e_we) begin
                pc = e_pc;
                if (m_count < CNT_MAX) m_count++;
            end
            if (running) m_pend_v = 1'b0;
            else if (i_jump || i_branch_taken) begin
                m_pend_v = 1'b1;
                m_pend_t = i_jump ? i_jump_target : i_branch_target;
            end
            if (halt_act) m_mode = 3;
            else if (m_mode == 0) m_mode = i_run ? 1 : (i_step ? 2 : 0);
            else if (m_mode == 1 && !i_run) m_mode = 0;
            else if (m_mode == 2 && running) m_mode = 0;
        end
    endtask

    task automatic cycle(input bit rst, input bit run, input bit step, input bit stall,
                         input bit br, input logic [31:0] bt,
                         input bit jmp, input logic [31:0] jt, input bit halt);
        applyStimulus(rst, run, step, stall, br, bt, jmp, jt, halt);
        checkOutput();
    endtask

    initial begin
        m_mode   = 0;
        m_pend_v = 1'b0;
        m_pend_t = 32'd0;
        m_count  = 0;
        pc       = 32'd0;
        i_reset = 1'b1; i_run = 1'b0; i_step = 1'b0; i_stall = 1'b0;
        i_branch_taken = 1'b0; i_branch_target = '0; i_jump = 1'b0; i_jump_target = '0;
        i_halt_detected = 1'b0; i_pc = '0;
        @(posedge i_clock);

        // Reset holds outputs low even with a live jump request.
        cycle(1, 1, 0, 0, 0, 0, 1, 32'h200, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Run from 0: writes 4, 8, 12, counter reaches 3.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkVal("pc_after_run3", {32'd0, pc}, 64'h0C);

        // Branch arrives during a two-cycle stall and is applied afterwards.
        cycle(0, 1, 0, 1, 1, 32'h40, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkVal("pc_after_pending", {32'd0, pc}, 64'h40);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Jump beats branch in the same cycle.
        cycle(0, 1, 0, 0, 1, 32'h80, 1, 32'h100, 0);
        checkVal("pc_after_jump", {32'd0, pc}, 64'h100);

        // HALT on the wrong path of a taken branch is ignored.
        cycle(0, 1, 0, 0, 1, 32'h10, 0, 0, 1);
        checkVal("pc_after_halt_branch", {32'd0, pc}, 64'h10);

        // HALT while stalled is ignored, then taken at PC 0x20.
        pc = 32'h20;
        cycle(0, 1, 0, 1, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
        checkVal("pc_held_on_halt", {32'd0, pc}, 64'h20);

        // Single step issued under a three-cycle stall.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("pc_after_step", {32'd0, pc}, 64'h04);

        // PC wrap at the top of the address space.
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        pc = 32'hFFFF_FFFC;
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkVal("pc_wrap", {32'd0, pc}, 64'h0);

        // Counter saturation, then reset mid-run.
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checkVal("count_saturated", {60'd0, o_cycle_count}, CNT_MAX);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 40) == 0, ($urandom % 8) != 0, ($urandom % 4) == 0,
                  ($urandom % 3) == 0, ($urandom % 6) == 0, {$urandom, 2'b00} >> 2 << 2,
                  ($urandom % 8) == 0, $urandom & 32'hFFFF_FFFC, ($urandom % 12) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
